divider_stream: RTL



---
 rtl/divider_pkg.sv | 32 +++
 rtl/div_step.sv | 39 +++
 rtl/divider_stream.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and helpers for the streaming restoring divider.
// State encodings are fixed constants so existing checkers keep matching.
package divider_pkg;

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] BUSY_ENC = 2'd1;
  localparam logic [1:0] DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    IDLE = IDLE_ENC,
    BUSY = BUSY_ENC,
    DONE = DONE_ENC
  } state_t;

  localparam int MAX_WIDTH = 64;

  function automatic int steps(input int width, input int bpc);
    return width / bpc;
  endfunction

  // Magnitude of a width-bit value; MIN maps to itself, read as 2^(width-1).
  function automatic logic [MAX_WIDTH-1:0] abs_mag(input logic [MAX_WIDTH-1:0] value,
                                                   input logic sign,
                                                   input int width);
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] res;
    mask = (width >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << width) - MAX_WIDTH'(1));
    res  = (sign && value[width-1]) ? (~value + MAX_WIDTH'(1)) : value;
    return res & mask;
  endfunction

endpackage

// File: rtl/div_step.sv
// Combinational block of BITS_PER_CYCLE restoring division steps.
// The partial remainder carries one extra bit so the borrow is the trial MSB.
module div_step
  import divider_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic [WIDTH:0]            rem_in,
  input  logic [WIDTH-1:0]          dvd_in,
  input  logic [WIDTH-1:0]          dsr,
  output logic [WIDTH:0]            rem_out,
  output logic [WIDTH-1:0]          dvd_out,
  output logic [BITS_PER_CYCLE-1:0] q_bits
);

  always_comb begin : step_chain
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] dvd;
    rem    = rem_in;
    dvd    = dvd_in;
    diff   = '0;
    q_bits = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rem  = {rem[WIDTH-1:0], dvd[WIDTH-1]};
      dvd  = {dvd[WIDTH-2:0], 1'b0};
      diff = rem - {1'b0, dsr};
      // Quotient bits are produced MSB first within the group.
      if (!diff[WIDTH]) begin
        rem                          = diff;
        q_bits[BITS_PER_CYCLE-1-i]   = 1'b1;
      end
    end
    rem_out = rem;
    dvd_out = dvd;
  end

endmodule

// File: rtl/divider_stream.sv
// Streaming signed/unsigned restoring divider with valid/ready on both sides.
// Handshake: a transfer happens on a rising edge where valid && ready; valid is held until then.
module divider_stream
  import divider_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int BITS_PER_CYCLE = 1,
  parameter int TAG_WIDTH      = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [WIDTH-1:0]     in_dividend,
  input  logic [WIDTH-1:0]     in_divisor,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_quotient,
  output logic [WIDTH-1:0]     out_remainder,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_div_by_zero,
  output logic                 out_overflow
);

  localparam int STEPS = steps(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = $clog2(STEPS + 1);

  generate
    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
      $error("divider_stream: WIDTH must be in 2..64");
    end
    if (BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
      $error("divider_stream: WIDTH must be a multiple of BITS_PER_CYCLE");
    end
    if (TAG_WIDTH < 1) begin : g_bad_tag
      $error("divider_stream: TAG_WIDTH must be at least 1");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state;
  logic [WIDTH:0]       rem_q;
  logic [WIDTH-1:0]     dvd_q;
  logic [WIDTH-1:0]     dsr_q;
  logic [WIDTH-1:0]     quo_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 neg_quo_q;
  logic                 neg_rem_q;
  logic                 ovf_q;

  logic [WIDTH:0]          rem_nx;
  logic [WIDTH-1:0]        dvd_nx;
  logic [BITS_PER_CYCLE-1:0] q_bits;
  logic [WIDTH-1:0]        dvd_mag;
  logic [WIDTH-1:0]        dsr_mag;
  logic [WIDTH-1:0]        quo_full;
  logic [WIDTH-1:0]        quo_fix;
  logic [WIDTH-1:0]        rem_fix;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  assign dvd_mag  = WIDTH'(abs_mag(MAX_WIDTH'(in_dividend), in_sign, WIDTH));
  assign dsr_mag  = WIDTH'(abs_mag(MAX_WIDTH'(in_divisor), in_sign, WIDTH));
  assign quo_full = (quo_q << BITS_PER_CYCLE) | WIDTH'(q_bits);
  // Truncating division: quotient sign from operand signs, remainder follows the dividend.
  assign quo_fix  = neg_quo_q ? -quo_full : quo_full;
  assign rem_fix  = neg_rem_q ? -rem_nx[WIDTH-1:0] : rem_nx[WIDTH-1:0];

  div_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .rem_in  (rem_q),
    .dvd_in  (dvd_q),
    .dsr     (dsr_q),
    .rem_out (rem_nx),
    .dvd_out (dvd_nx),
    .q_bits  (q_bits)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      rem_q           <= '0;
      dvd_q           <= '0;
      dsr_q           <= '0;
      quo_q           <= '0;
      cnt_q           <= '0;
      neg_quo_q       <= 1'b0;
      neg_rem_q       <= 1'b0;
      ovf_q           <= 1'b0;
      out_quotient    <= '0;
      out_remainder   <= '0;
      out_tag         <= '0;
      out_div_by_zero <= 1'b0;
      out_overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dsr_q        <= dsr_mag;
            dvd_q        <= dvd_mag;
            rem_q        <= '0;
            quo_q        <= '0;
            cnt_q        <= CNT_W'(STEPS);
            neg_quo_q    <= in_sign && (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
            neg_rem_q    <= in_sign && in_dividend[WIDTH-1];
            ovf_q        <= in_sign && (in_dividend == MIN_VAL) && (in_divisor == '1);
            out_tag      <= in_tag;
            out_overflow <= 1'b0;
            if (in_divisor == '0) begin
              state           <= DONE;
              out_quotient    <= '1;
              out_remainder   <= in_dividend;
              out_div_by_zero <= 1'b1;
            end else begin
              state           <= BUSY;
              out_div_by_zero <= 1'b0;
            end
          end
        end
        BUSY: begin
          rem_q <= rem_nx;
          dvd_q <= dvd_nx;
          quo_q <= quo_full;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state         <= DONE;
            out_quotient  <= quo_fix;
            out_remainder <= rem_fix;
            out_overflow  <= ovf_q;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
